// File: rtl/memory_project_pkg.sv
// Shared memory-path defaults and the readout scan state encoding.
package memory_project_pkg;

  localparam int DEFAULT_ADDRESSBITS = 10;
  localparam int DEFAULT_DATABITS    = 32;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    ISSUE,
    DRAIN
  } scan_state_t;

endpackage

// File: rtl/readout_fifo.sv
// Output buffer for the scanner; pop data is combinational from the head entry.
// Push is dropped only when full without a simultaneous pop; push+pop is legal at any occupancy.
module readout_fifo #(
  parameter int WIDTH = 42,
  parameter int DEPTH = 4
) (
  input  logic                     clock,
  input  logic                     resetN,
  input  logic                     push,
  input  logic [WIDTH-1:0]         pushData,
  input  logic                     pop,
  output logic [WIDTH-1:0]         popData,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wrPtr;
  logic [AW-1:0]    rdPtr;
  logic             doPush;
  logic             doPop;

  assign empty   = (count == '0);
  assign full    = (count == CW'(DEPTH));
  assign doPop   = pop && !empty;
  assign doPush  = push && (!full || doPop);
  assign popData = mem[rdPtr];

  always_ff @(posedge clock or negedge resetN) begin
    if (!resetN) begin
      wrPtr <= '0;
      rdPtr <= '0;
      count <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      if (doPush) begin
        mem[wrPtr] <= pushData;
        wrPtr      <= wrPtr + AW'(1);
      end
      if (doPop) rdPtr <= rdPtr + AW'(1);
      case ({doPush, doPop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/storage_readout_scanner.sv
// Sweeps storage once per startScan and streams non-zero words (ascending address) out valid/ready.
// First beat >= READLATENCY+1 cycles after the first strobe; reads stall on FIFO credit. Option: HIT_COUNT_EN.
module storage_readout_scanner
  import memory_project_pkg::*;
#(
  parameter int ADDRESSBITS = DEFAULT_ADDRESSBITS,
  parameter int DATABITS    = DEFAULT_DATABITS,
  parameter int READLATENCY = 2,
  parameter int OUTDEPTH    = 4
) (
  input  logic                   clock,
  input  logic                   resetN,
  input  logic                   startScan,
  input  logic                   readReady,
  output logic                   memReadEnable,
  output logic [ADDRESSBITS-1:0] memAddress,
  input  logic [DATABITS-1:0]    memData,
  output logic                   outValid,
  input  logic                   outReady,
  output logic [DATABITS-1:0]    outData,
  output logic [ADDRESSBITS-1:0] outAddress,
  output logic                   scanBusy,
  output logic                   scanDone
`ifdef HIT_COUNT_EN
  ,
  output logic [ADDRESSBITS:0]   hitCount
`endif
);

  localparam logic [ADDRESSBITS-1:0] LAST_ADDR = '1;
  localparam int FCW = $clog2(OUTDEPTH) + 1;
  localparam int CW  = $clog2(OUTDEPTH + READLATENCY + 1) + 1;
  localparam int FW  = DATABITS + ADDRESSBITS;

  scan_state_t            state, nextState;
  logic [ADDRESSBITS-1:0] counter;
  logic [READLATENCY-1:0] pipeValid;
  logic [ADDRESSBITS-1:0] pipeAddr [READLATENCY];
  logic                   issue, startAccept, credit, pipeBusy;
  logic                   fifoPush, fifoEmpty, fifoFull;
  logic [FCW-1:0]         fifoCount;
  logic [CW-1:0]          inFlight;
  logic [FW-1:0]          popData;

  // Every read in flight already owns a FIFO slot, so the FIFO can never overflow.
  always_comb begin
    inFlight = '0;
    for (int i = 0; i < READLATENCY; i++) inFlight = inFlight + CW'(pipeValid[i]);
  end

  assign credit      = (CW'(fifoCount) + inFlight + CW'(1)) <= CW'(OUTDEPTH);
  assign pipeBusy    = |pipeValid;
  assign startAccept = (state == IDLE) && startScan;

  always_comb begin
    nextState = state;
    issue     = 1'b0;
    scanDone  = 1'b0;
    unique case (state)
      IDLE:  if (startScan) nextState = WAIT;
      WAIT:  if (readReady) nextState = ISSUE;
      ISSUE: if (readReady && credit) begin
               issue = 1'b1;
               if (counter == LAST_ADDR) nextState = DRAIN;
             end
      DRAIN: if (!pipeBusy && fifoEmpty) begin
               scanDone  = 1'b1;
               nextState = IDLE;
             end
      default: nextState = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge resetN) begin
    if (!resetN) begin
      state   <= IDLE;
      counter <= '0;
    end else begin
      state <= nextState;
      if (startAccept) counter <= '0;
      else if (issue && counter != LAST_ADDR) counter <= counter + ADDRESSBITS'(1);
    end
  end

  // Address tags travel alongside the storage latency so they meet memData on the landing beat.
  always_ff @(posedge clock or negedge resetN) begin
    if (!resetN) begin
      pipeValid <= '0;
      for (int i = 0; i < READLATENCY; i++) pipeAddr[i] <= '0;
    end else begin
      pipeValid[0] <= issue;
      pipeAddr[0]  <= counter;
      for (int i = 1; i < READLATENCY; i++) begin
        pipeValid[i] <= pipeValid[i-1];
        pipeAddr[i]  <= pipeAddr[i-1];
      end
    end
  end

  assign fifoPush = pipeValid[READLATENCY-1] && (memData != '0);

  readout_fifo #(
    .WIDTH(FW),
    .DEPTH(OUTDEPTH)
  ) u_fifo (
    .clock    (clock),
    .resetN   (resetN),
    .push     (fifoPush),
    .pushData ({memData, pipeAddr[READLATENCY-1]}),
    .pop      (outReady),
    .popData  (popData),
    .count    (fifoCount),
    .full     (fifoFull),
    .empty    (fifoEmpty)
  );

  assert property (@(posedge clock) disable iff (!resetN) !(fifoFull && fifoPush));

  assign memReadEnable         = issue;
  assign memAddress            = counter;
  assign outValid              = !fifoEmpty;
  assign {outData, outAddress} = popData;
  assign scanBusy              = (state != IDLE) && !scanDone;

`ifdef HIT_COUNT_EN
  always_ff @(posedge clock or negedge resetN) begin
    if (!resetN) hitCount <= '0;
    else if (startAccept) hitCount <= '0;
    else if (fifoPush) hitCount <= hitCount + (ADDRESSBITS+1)'(1);
  end
`endif

endmodule

// File: tb/tb_storage_readout_scanner.sv
// Randomized bench for storage_readout_scanner against a queue-based expected-beat model.
module tb_storage_readout_scanner;

  localparam int AB = 3;
  localparam int DB = 32;
  localparam int RL = 2;
  localparam int OD = 4;
  localparam int NW = 1 << AB;

  logic          clock = 1'b0;
  logic          resetN = 1'b0;
  logic          startScan = 1'b0;
  logic          readReady = 1'b0;
  logic          outReady = 1'b0;
  logic          memReadEnable;
  logic [AB-1:0] memAddress;
  logic [DB-1:0] memData;
  logic          outValid;
  logic [DB-1:0] outData;
  logic [AB-1:0] outAddress;
  logic          scanBusy;
  logic          scanDone;
`ifdef HIT_COUNT_EN
  logic [AB:0]   hitCount;
`endif

  storage_readout_scanner #(
    .ADDRESSBITS(AB), .DATABITS(DB), .READLATENCY(RL), .OUTDEPTH(OD)
  ) dut (
    .clock(clock), .resetN(resetN), .startScan(startScan), .readReady(readReady),
    .memReadEnable(memReadEnable), .memAddress(memAddress), .memData(memData),
    .outValid(outValid), .outReady(outReady), .outData(outData), .outAddress(outAddress),
    .scanBusy(scanBusy), .scanDone(scanDone)
`ifdef HIT_COUNT_EN
    , .hitCount(hitCount)
`endif
  );

  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Storage model: fixed-latency read; non-strobe cycles return junk that must never be pushed.
  logic [DB-1:0] mem [NW];
  logic [DB-1:0] dl  [RL];
  always @(posedge clock) begin
    dl[0] <= memReadEnable ? mem[memAddress] : DB'($urandom);
    for (int i = 1; i < RL; i++) dl[i] <= dl[i-1];
  end
  assign memData = dl[RL-1];

  // Reference model and observation state.
  logic [AB+DB-1:0] exp_q[$];
  logic [AB+DB-1:0] held;
  bit  hold_pending;
  int  cyc, scan_t, rdy_mode, hold_t;
  bit  gap;
  int  strobes, next_addr, done_count, beats, hits;
  int  last_beat_cyc, done_cyc, first_strobe_cyc, first_valid_cyc, last_strobe_cyc;

  always @(negedge clock) begin
    if (resetN) begin
      if (memReadEnable) begin
        check_eq("strobe_rr", readReady, 1);
        check_eq("strobe_addr", memAddress, next_addr);
        if (strobes == 0) first_strobe_cyc = cyc;
        strobes++;
        next_addr++;
        last_strobe_cyc = cyc;
      end
      if (hold_pending) begin
        check_eq("hold_vld", outValid, 1);
        check_eq("hold_dat", {outAddress, outData}, held);
      end
      if (outValid && first_valid_cyc < 0) first_valid_cyc = cyc;
      if (outValid && outReady) begin
        if (exp_q.size() == 0) check_eq("extra_beat", outValid, 0);
        else check_eq("beat", {outAddress, outData}, exp_q.pop_front());
        beats++;
        last_beat_cyc = cyc;
      end
      hold_pending = outValid && !outReady;
      held = {outAddress, outData};
      if (scanDone) begin
        check_eq("done_busy", scanBusy, 0);
        done_count++;
        done_cyc = cyc;
      end
    end
  end

  task automatic step;
    @(posedge clock);
    #1;
    cyc++;
    scan_t++;
    readReady = !(gap && scan_t >= 3 && scan_t <= 10);
    case (rdy_mode)
      1:       outReady = 1'($urandom_range(0, 1));
      2:       outReady = (scan_t > hold_t);
      default: outReady = 1'b1;
    endcase
  endtask

  task automatic clear_model;
    exp_q.delete();
    hold_pending = 0;
    strobes = 0; next_addr = 0; done_count = 0; beats = 0; hits = 0;
    first_valid_cyc = -1; first_strobe_cyc = -1;
    for (int a = 0; a < NW; a++)
      if (mem[a] != 0) begin
        exp_q.push_back({a[AB-1:0], mem[a]});
        hits++;
      end
  endtask

  task automatic start_scan(input string tag);
    startScan = 1'b1;
    scan_t = 0;
    step;
    startScan = 1'b0;
    check_eq({tag, "_busy"}, scanBusy, 1);
  endtask

  task automatic run_scan(input string tag, input int mode, input bit gap_i, input int hold_i,
                          input int restart_at);
    rdy_mode = mode; gap = gap_i; hold_t = hold_i;
    clear_model();
    start_scan(tag);
    if (hold_i > 0) begin
      while (scan_t < hold_i) step;
      check_eq({tag, "_credit_strobes"}, strobes, OD);
    end
    for (int n = 0; n < 400 && done_count == 0; n++) begin
      startScan = (restart_at > 0 && scan_t == restart_at);
      step;
    end
    startScan = 1'b0;
    repeat (6) step;
    check_eq({tag, "_done_count"}, done_count, 1);
    check_eq({tag, "_left"}, exp_q.size(), 0);
    check_eq({tag, "_strobes"}, strobes, NW);
    check_eq({tag, "_idle_busy"}, scanBusy, 0);
`ifdef HIT_COUNT_EN
    check_eq({tag, "_hits"}, hitCount, hits);
`endif
  endtask

  initial begin
    cyc = 0; scan_t = 0; rdy_mode = 0; gap = 0; hold_t = 0;
    for (int a = 0; a < NW; a++) mem[a] = '0;
    clear_model();
    repeat (3) step;
    check_eq("rst_outs", {memReadEnable, memAddress, outValid, outData, outAddress, scanBusy, scanDone}, 0);
    resetN = 1'b1;
    repeat (2) step;

    // Sparse memory, always ready.
    mem[0] = 0; mem[1] = 5; mem[2] = 0; mem[3] = 0; mem[4] = 9; mem[5] = 0; mem[6] = 0; mem[7] = 7;
    run_scan("t1", 0, 0, 0, 0);
    check_eq("t1_beats", beats, 3);
    check_eq("t1_done_gap", done_cyc - last_beat_cyc, 1);
    check_eq("t1_first_lat", (first_valid_cyc - first_strobe_cyc) >= RL + 1, 1);

    // All-zero memory.
    for (int a = 0; a < NW; a++) mem[a] = '0;
    run_scan("t2", 0, 0, 0, 0);
    check_eq("t2_beats", beats, 0);
    check_eq("t2_done_lat", done_cyc - last_strobe_cyc, RL + 1);

    // Full memory with consumer stalled for 20 cycles.
    for (int a = 0; a < NW; a++) mem[a] = DB'($urandom_range(1, 32'h7fff_ffff));
    run_scan("t3", 2, 0, 20, 0);
    check_eq("t3_beats", beats, NW);

    // readReady gap mid-scan.
    for (int a = 0; a < NW; a++) mem[a] = ($urandom_range(0, 1) != 0) ? DB'($urandom) : '0;
    run_scan("t4", 0, 1, 0, 0);

    // Reset in the middle of ISSUE, then a fresh sweep.
    rdy_mode = 0; gap = 0;
    clear_model();
    start_scan("t5a");
    repeat (4) step;
    resetN = 1'b0;
    #1;
    check_eq("t5_rst_outs", {memReadEnable, memAddress, outValid, outData, outAddress, scanBusy, scanDone}, 0);
    repeat (2) step;
    check_eq("t5_rst_done", done_count, 0);
    resetN = 1'b1;
    repeat (2) step;
    run_scan("t5b", 0, 0, 0, 0);

    // Restart pulse during ISSUE with a random consumer.
    mem[0] = 0; mem[1] = 5; mem[2] = 0; mem[3] = 0; mem[4] = 9; mem[5] = 0; mem[6] = 0; mem[7] = 7;
    run_scan("t6", 1, 0, 0, 4);
    check_eq("t6_beats", beats, 3);

    // Random memories, random consumer and readReady gaps.
    for (int k = 0; k < 4; k++) begin
      for (int a = 0; a < NW; a++) mem[a] = ($urandom_range(0, 2) != 0) ? DB'($urandom) : '0;
      run_scan("rnd", 1, 1'($urandom_range(0, 1)), 0, 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
